time_set_ctrl: RTL and testbench

Sequencing controller for the timekeeping counters: drives the `en`/`upDown` inputs of the seconds and minutes modulo-60 counters and the hours modulo-24 counter. In RUN it cascades 1 Hz ticks through seconds, minutes and hours. In the two adjust states it routes debounced up/down button pulses to the selected field. It sits between the tick generator / button debouncers and the three counter instances.

---
 rtl/time_set_ctrl_if.sv | 28 ++
 rtl/time_set_ctrl.sv | 107 ++++++++++
 tb/tb_time_set_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/time_set_ctrl_if.sv
// Signal bundle between the tick/button front end, the time counters and time_set_ctrl.
// The master side drives strobes and counter values; the slave side returns enables and mode.
interface time_set_ctrl_if;
    logic       tick;
    logic       btn_mode;
    logic       btn_up;
    logic       btn_down;
    logic [5:0] sec_count;
    logic [5:0] min_count;
    logic [4:0] hr_count;
    logic       sec_en;
    logic       sec_updown;
    logic       min_en;
    logic       min_updown;
    logic       hr_en;
    logic       hr_updown;
    logic [1:0] mode;

    modport master (
        output tick, btn_mode, btn_up, btn_down, sec_count, min_count, hr_count,
        input  sec_en, sec_updown, min_en, min_updown, hr_en, hr_updown, mode
    );

    modport slave (
        input  tick, btn_mode, btn_up, btn_down, sec_count, min_count, hr_count,
        output sec_en, sec_updown, min_en, min_updown, hr_en, hr_updown, mode
    );
endinterface

// File: rtl/time_set_ctrl.sv
// Run/adjust sequencer driving the en/updown inputs of the sec/min/hour counters.
// Optional adjust-mode inactivity timeout is built when TIMEOUT_EN is defined.
module time_set_ctrl #(
    parameter int unsigned HR_MAX    = 23,
    parameter int unsigned TIMEOUT_S = 10
) (
    input  logic           clk,
    input  logic           rst,
    time_set_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        StRun    = 2'b00,
        StSetMin = 2'b01,
        StSetHr  = 2'b10,
        StBad    = 2'b11
    } state_e;

    state_e state_q;
    logic   sec_en_q, min_en_q, hr_en_q;
    logic   sec_ud_q, min_ud_q, hr_ud_q;
    logic   adj_pulse, sec_wrap, min_wrap;

    // Counters wrap on their own, so the hour value and HR_MAX only matter downstream.
    logic   unused_hr;
    assign unused_hr = ^{bus.hr_count, 5'(HR_MAX)};

    assign adj_pulse = bus.btn_up ^ bus.btn_down;
    assign sec_wrap  = (bus.sec_count == 6'd59);
    assign min_wrap  = (bus.min_count == 6'd59);

`ifdef TIMEOUT_EN
    localparam int unsigned ToW = $clog2(TIMEOUT_S + 1);
    logic [ToW-1:0] to_q;
`else
    logic unused_to;
    assign unused_to = ^{32'(TIMEOUT_S)};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StRun;
            sec_en_q <= 1'b0;
            min_en_q <= 1'b0;
            hr_en_q  <= 1'b0;
            sec_ud_q <= 1'b1;
            min_ud_q <= 1'b1;
            hr_ud_q  <= 1'b1;
`ifdef TIMEOUT_EN
            to_q     <= '0;
`endif
        end else begin
            // Enables are single-cycle; direction falls back to up after any pulse.
            sec_en_q <= 1'b0;
            min_en_q <= 1'b0;
            hr_en_q  <= 1'b0;
            sec_ud_q <= 1'b1;
            min_ud_q <= 1'b1;
            hr_ud_q  <= 1'b1;
            case (state_q)
                StRun: begin
                    if (bus.tick) begin
                        sec_en_q <= 1'b1;
                        min_en_q <= sec_wrap;
                        hr_en_q  <= sec_wrap && min_wrap;
                    end
                    if (bus.btn_mode) state_q <= StSetMin;
                end
                StSetMin: begin
                    if (bus.btn_mode) begin
                        state_q <= StSetHr;
                    end else if (adj_pulse) begin
                        min_en_q <= 1'b1;
                        min_ud_q <= bus.btn_up;
                    end
                end
                StSetHr: begin
                    if (bus.btn_mode) begin
                        state_q <= StRun;
                    end else if (adj_pulse) begin
                        hr_en_q <= 1'b1;
                        hr_ud_q <= bus.btn_up;
                    end
                end
                default: state_q <= StRun;
            endcase
`ifdef TIMEOUT_EN
            if (state_q == StRun || state_q == StBad ||
                bus.btn_mode || bus.btn_up || bus.btn_down) begin
                to_q <= '0;
            end else if (to_q == ToW'(TIMEOUT_S)) begin
                state_q <= StRun;
                to_q    <= '0;
            end else if (bus.tick) begin
                to_q <= to_q + 1'b1;
            end
`endif
        end
    end

    assign bus.sec_en     = sec_en_q;
    assign bus.min_en     = min_en_q;
    assign bus.hr_en      = hr_en_q;
    assign bus.sec_updown = sec_ud_q;
    assign bus.min_updown = min_ud_q;
    assign bus.hr_updown  = hr_ud_q;
    assign bus.mode       = state_q;
endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: per-cycle model comparison plus literal spot checks.
module tb_time_set_ctrl;
    localparam int unsigned TimeoutS = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    time_set_ctrl_if bus ();

    time_set_ctrl #(
        .HR_MAX   (23),
        .TIMEOUT_S(TimeoutS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model: mode as an integer 0/1/2, expected outputs recomputed from the rules each edge.
    int   m_mode      = 0;
    int   m_idle      = 0;
    bit   model_valid = 1'b0;
    logic e_sen, e_men, e_hen, e_sud, e_mud, e_hud;

    always @(posedge clk) begin
        int nxt;
        e_sen = 1'b0; e_men = 1'b0; e_hen = 1'b0;
        e_sud = 1'b1; e_mud = 1'b1; e_hud = 1'b1;
        if (rst) begin
            m_mode = 0;
            m_idle = 0;
            model_valid = 1'b1;
        end else begin
            nxt = m_mode;
            if (m_mode == 0) begin
                if (bus.tick) begin
                    e_sen = 1'b1;
                    e_men = (bus.sec_count == 59);
                    e_hen = (bus.sec_count == 59) && (bus.min_count == 59);
                end
                if (bus.btn_mode) nxt = 1;
                m_idle = 0;
            end else begin
                if (bus.btn_mode) begin
                    nxt = (m_mode == 1) ? 2 : 0;
                end else if (bus.btn_up != bus.btn_down) begin
                    if (m_mode == 1) begin e_men = 1'b1; e_mud = bus.btn_up; end
                    else begin e_hen = 1'b1; e_hud = bus.btn_up; end
                end
`ifdef TIMEOUT_EN
                if (bus.btn_mode || bus.btn_up || bus.btn_down) m_idle = 0;
                else if (m_idle == TimeoutS) begin nxt = 0; m_idle = 0; end
                else if (bus.tick) m_idle++;
`endif
            end
            m_mode = nxt;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            vectors++;
            if ({bus.sec_en, bus.min_en, bus.hr_en, bus.sec_updown, bus.min_updown,
                 bus.hr_updown, bus.mode} !==
                {e_sen, e_men, e_hen, e_sud, e_mud, e_hud, 2'(m_mode)}) begin
                miscompares++;
                $display("FAIL cycle_model t=%0t got en=%b%b%b ud=%b%b%b mode=%b exp en=%b%b%b ud=%b%b%b mode=%b",
                         $time, bus.sec_en, bus.min_en, bus.hr_en, bus.sec_updown,
                         bus.min_updown, bus.hr_updown, bus.mode, e_sen, e_men, e_hen,
                         e_sud, e_mud, e_hud, 2'(m_mode));
            end
        end
    end

    // Literal check of {sec_en,min_en,hr_en,sec_ud,min_ud,hr_ud,mode} (8 bits).
    task automatic chk(input string name, input logic [7:0] exp);
        logic [7:0] got;
        got = {bus.sec_en, bus.min_en, bus.hr_en, bus.sec_updown, bus.min_updown,
               bus.hr_updown, bus.mode};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    task automatic apply(input logic t, input logic m, input logic u, input logic d);
        bus.tick = t; bus.btn_mode = m; bus.btn_up = u; bus.btn_down = d;
        @(posedge clk);
        #1;
        bus.tick = 1'b0; bus.btn_mode = 1'b0; bus.btn_up = 1'b0; bus.btn_down = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            apply(1'b1, 1'b0, 1'b0, 1'b0);
            apply(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        bus.tick = 1'b0; bus.btn_mode = 1'b0; bus.btn_up = 1'b0; bus.btn_down = 1'b0;
        bus.sec_count = 6'd0; bus.min_count = 6'd0; bus.hr_count = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset", 8'b000_111_00);

        bus.sec_count = 6'd58;
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        chk("run_tick_58", 8'b100_111_00);
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        chk("run_tick_release", 8'b000_111_00);

        bus.sec_count = 6'd59; bus.min_count = 6'd59; bus.hr_count = 5'd23;
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        chk("run_full_carry", 8'b111_111_00);
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        chk("run_carry_one_cycle", 8'b000_111_00);

        apply(1'b0, 1'b1, 1'b0, 1'b0);
        chk("mode_set_min", 8'b000_111_01);
        apply(1'b0, 1'b1, 1'b0, 1'b0);
        chk("mode_set_hr", 8'b000_111_10);
        apply(1'b0, 1'b0, 1'b0, 1'b1);
        chk("hr_down", 8'b001_110_10);
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        chk("hr_ud_restore", 8'b000_111_10);
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        chk("tick_in_set_hr", 8'b000_111_10);
        apply(1'b0, 1'b0, 1'b1, 1'b0);
        chk("hr_up", 8'b001_111_10);

        apply(1'b0, 1'b1, 1'b0, 1'b0);
        chk("mode_wrap_run", 8'b000_111_00);
        apply(1'b0, 1'b1, 1'b0, 1'b0);
        bus.min_count = 6'd59;
        apply(1'b0, 1'b0, 1'b1, 1'b0);
        chk("min_up_no_carry", 8'b010_111_01);
        apply(1'b0, 1'b0, 1'b1, 1'b1);
        chk("up_down_together", 8'b000_111_01);
        apply(1'b0, 1'b0, 1'b0, 1'b1);
        chk("min_down", 8'b010_101_01);
        apply(1'b0, 1'b1, 1'b1, 1'b0);
        chk("mode_beats_up", 8'b000_111_10);
        apply(1'b0, 1'b1, 1'b0, 1'b0);

        apply(1'b0, 1'b0, 1'b1, 1'b1);
        chk("run_ignores_buttons", 8'b000_111_00);
        bus.sec_count = 6'd59; bus.min_count = 6'd10;
        apply(1'b1, 1'b1, 1'b0, 1'b0);
        chk("tick_with_mode", 8'b110_111_01);
        apply(1'b0, 1'b1, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 1'b0, 1'b0);
        chk("back_to_run", 8'b000_111_00);

        // Adjust-mode inactivity: 9 ticks, a press, 9 ticks, then 10 more.
        apply(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(9);
        apply(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(9);
        chk("idle_19_still_set", 8'b000_111_01);
        ticks(10);
`ifdef TIMEOUT_EN
        chk("timeout_to_run", 8'b000_111_00);
`else
        chk("no_timeout", 8'b000_111_01);
        apply(1'b0, 1'b1, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 1'b0, 1'b0);
`endif

        bus.sec_count = 6'd59; bus.min_count = 6'd59;
        rst = 1'b1;
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        chk("reset_cancels_tick", 8'b000_111_00);
        rst = 1'b0;

        apply(1'b0, 1'b1, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        apply(1'b0, 1'b0, 1'b0, 1'b1);
        chk("reset_cancels_adjust", 8'b000_111_00);
        rst = 1'b0;
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
